// File: rtl/player_cmd_pkg.sv
// Shared definitions for the player command scheduler.
// Holds the instruction field widths, opcodes, direction codes, the
// arbitration FSM state enum and a helper that packs an instruction word.
package player_cmd_pkg;

    localparam int OP_W  = 4;
    localparam int ARG_W = 8;
    localparam int CMD_W = 16;

    localparam logic [OP_W-1:0] OP_HPY = 4'b0001;
    localparam logic [OP_W-1:0] OP_DPY = 4'b0010;
    localparam logic [OP_W-1:0] OP_MOV = 4'b0101;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_LEFT  = 2'd1;
    localparam logic [1:0] DIR_DOWN  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } sched_state_e;

    // Instruction word layout: {op, arg, 4'b0000}
    function automatic logic [CMD_W-1:0] make_cmd(input logic [OP_W-1:0]  op,
                                                  input logic [ARG_W-1:0] arg);
        return {op, arg, 4'b0000};
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Hit-event FIFO: synchronous, first-in first-out, DEPTH entries of W bits.
// Ports:
//   clk, rst_n    clock, async active-low reset
//   push, wdata   write request/data (ignored when full or flushing)
//   pop, rdata    read request; rdata shows the head combinationally
//   flush         empties the FIFO on the next edge, overrides push/pop
//   full, empty   occupancy flags, derived from the registered count
module cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 9
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    input  logic         flush,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    // A push coinciding with a pop while full is refused: full is the
    // pre-edge state, so the write side never sees the freed slot early.
    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & ~empty & ~flush;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/player_cmd_sched.sv
// Player command scheduler: shares the player-update datapath between
// movement and hit events, issuing one instruction at a time over a
// valid/ready handshake. Hits queue in a FIFO, moves coalesce into one slot,
// hits win arbitration unless a pending move has waited STARVE hit grants.
// Ports:
//   mv_valid/mv_dir                      move request, latest direction wins
//   hit_valid/hit_heal/hit_amt/hit_ready hit event push, ready = FIFO not full
//   flush                                drop queued hits, pending move, starve count
//   cmd_valid/cmd/cmd_ready              instruction handshake
//   drop_cnt                             saturating count of hits lost to a full FIFO
//
// state   | meaning
// ST_IDLE | no instruction presented; pick hit or move to load
// ST_HOLD | cmd_valid high, cmd held until cmd_ready
module player_cmd_sched
    import player_cmd_pkg::*;
#(
    parameter int         DEPTH    = 4,
    parameter int         STARVE   = 3,
    parameter logic [7:0] HEAL_AMT = 8'd10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mv_valid,
    input  logic [1:0]       mv_dir,
    input  logic             hit_valid,
    input  logic             hit_heal,
    input  logic [7:0]       hit_amt,
    output logic             hit_ready,
    input  logic             flush,
    output logic             cmd_valid,
    output logic [CMD_W-1:0] cmd,
    input  logic             cmd_ready,
    output logic [7:0]       drop_cnt
);

    localparam int SW = $clog2(STARVE + 1);

    sched_state_e     state_q, state_d;
    logic [CMD_W-1:0] cmd_q, cmd_d;
    logic             mv_pend_q;
    logic [1:0]       mv_dir_q;
    logic [SW-1:0]    starve_q;
    logic [7:0]       drop_q;

    logic             hit_evt;
    logic             fifo_full;
    logic             fifo_empty;
    logic [8:0]       fifo_head;
    logic             grant_hit;
    logic             grant_mv;

    // Zero-amount damage is a no-op for the player, so it is not even an event.
    assign hit_evt = hit_valid & ~flush & (hit_heal | (hit_amt != 8'd0));

    cmd_fifo #(
        .DEPTH (DEPTH),
        .W     (9)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (hit_evt),
        .wdata ({hit_heal, hit_amt}),
        .pop   (grant_hit),
        .flush (flush),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        grant_hit = 1'b0;
        grant_mv  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // No grant during flush: the FIFO entry or move would be
                // discarded in the same edge.
                if (!flush) begin
                    if (!fifo_empty && (!mv_pend_q || starve_q < SW'(STARVE))) begin
                        grant_hit = 1'b1;
                        cmd_d     = fifo_head[8] ? make_cmd(OP_HPY, HEAL_AMT)
                                                 : make_cmd(OP_DPY, fifo_head[7:0]);
                        state_d   = ST_HOLD;
                    end else if (mv_pend_q) begin
                        grant_mv = 1'b1;
                        cmd_d    = make_cmd(OP_MOV, {6'b0, mv_dir_q});
                        state_d  = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (cmd_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cmd_q     <= '0;
            mv_pend_q <= 1'b0;
            mv_dir_q  <= DIR_UP;
            starve_q  <= '0;
            drop_q    <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;

            // A new request in the same cycle a MOV is loaded re-arms the slot.
            if (flush) begin
                mv_pend_q <= 1'b0;
            end else if (mv_valid) begin
                mv_pend_q <= 1'b1;
                mv_dir_q  <= mv_dir;
            end else if (grant_mv) begin
                mv_pend_q <= 1'b0;
            end

            if (flush || grant_mv || (grant_hit && !mv_pend_q)) begin
                starve_q <= '0;
            end else if (grant_hit) begin
                starve_q <= starve_q + 1'b1;
            end

            if (hit_evt && fifo_full && drop_q != 8'hFF) begin
                drop_q <= drop_q + 1'b1;
            end
        end
    end

    assign cmd_valid = (state_q == ST_HOLD);
    assign cmd       = cmd_q;
    assign hit_ready = ~fifo_full;
    assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_player_cmd_sched.sv
// Bench for player_cmd_sched: directed scenarios plus random traffic,
// every cycle compared against a queue-based reference model.
module tb_player_cmd_sched;
    import player_cmd_pkg::*;

    localparam int DEPTH  = 4;
    localparam int STARVE = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mv_valid;
    logic [1:0]  mv_dir;
    logic        hit_valid;
    logic        hit_heal;
    logic [7:0]  hit_amt;
    logic        hit_ready;
    logic        flush;
    logic        cmd_valid;
    logic [15:0] cmd;
    logic        cmd_ready;
    logic [7:0]  drop_cnt;

    player_cmd_sched #(.DEPTH(DEPTH), .STARVE(STARVE), .HEAL_AMT(8'd10)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mv_valid  (mv_valid),
        .mv_dir    (mv_dir),
        .hit_valid (hit_valid),
        .hit_heal  (hit_heal),
        .hit_amt   (hit_amt),
        .hit_ready (hit_ready),
        .flush     (flush),
        .cmd_valid (cmd_valid),
        .cmd       (cmd),
        .cmd_ready (cmd_ready),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    logic [8:0]  m_q[$];
    bit          m_pend;
    logic [1:0]  m_dir;
    int          m_starve;
    bit          m_hold;
    logic [15:0] m_cmd;
    int          m_drop;

    logic [15:0] xfers[$];

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_pend   = 0;
        m_dir    = 2'd0;
        m_starve = 0;
        m_hold   = 0;
        m_cmd    = 16'h0000;
        m_drop   = 0;
    endtask

    // One clock edge of the scheduler's rules, using pre-edge inputs and state.
    task automatic model_step();
        bit         full_pre;
        bit         pend_pre;
        bit         took_move;
        logic [8:0] e;
        full_pre  = (m_q.size() == DEPTH);
        pend_pre  = m_pend;
        took_move = 0;
        if (m_hold) begin
            if (cmd_ready) m_hold = 0;
        end else if (!flush) begin
            if (m_q.size() > 0 && (!pend_pre || m_starve < STARVE)) begin
                e        = m_q.pop_front();
                m_cmd    = e[8] ? {4'h1, 8'd10, 4'h0} : {4'h2, e[7:0], 4'h0};
                m_starve = pend_pre ? m_starve + 1 : 0;
                m_hold   = 1;
            end else if (pend_pre) begin
                m_cmd     = {4'h5, 6'b0, m_dir, 4'h0};
                took_move = 1;
                m_starve  = 0;
                m_hold    = 1;
            end
        end
        if (hit_valid && !flush && (hit_heal || hit_amt != 8'd0)) begin
            if (full_pre) begin
                if (m_drop < 255) m_drop++;
            end else begin
                m_q.push_back({hit_heal, hit_amt});
            end
        end
        if (flush) begin
            m_q.delete();
            m_pend   = 0;
            m_starve = 0;
        end else if (mv_valid) begin
            m_pend = 1;
            m_dir  = mv_dir;
        end else if (took_move) begin
            m_pend = 0;
        end
    endtask

    task automatic cycle();
        if (cmd_valid && cmd_ready) xfers.push_back(cmd);
        @(posedge clk);
        model_step();
        #1;
        check_eq("cmd_valid", 16'(cmd_valid), 16'(m_hold));
        check_eq("cmd", cmd, m_cmd);
        check_eq("hit_ready", 16'(hit_ready), 16'(m_q.size() < DEPTH));
        check_eq("drop_cnt", 16'(drop_cnt), 16'(m_drop));
    endtask

    task automatic idle_inputs();
        mv_valid  = 0;
        mv_dir    = 2'd0;
        hit_valid = 0;
        hit_heal  = 0;
        hit_amt   = 8'd0;
        flush     = 0;
    endtask

    task automatic hit(input bit heal, input logic [7:0] amt);
        hit_valid = 1;
        hit_heal  = heal;
        hit_amt   = amt;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin : main
        logic [15:0] exp4 [6];
        exp4 = '{16'h2010, 16'h2020, 16'h2030, 16'h5000, 16'h2040, 16'h2050};

        idle_inputs();
        cmd_ready = 0;
        rst_n     = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_cmd_valid", 16'(cmd_valid), 16'h0);
        check_eq("rst_cmd", cmd, 16'h0000);
        check_eq("rst_hit_ready", 16'(hit_ready), 16'h1);
        check_eq("rst_drop_cnt", 16'(drop_cnt), 16'h0);
        rst_n = 1;
        run(1);

        // single move, accepted immediately
        mv_valid = 1; mv_dir = DIR_RIGHT; cmd_ready = 1;
        cycle();
        mv_valid = 0;
        cycle();
        check_eq("t1_valid", 16'(cmd_valid), 16'h1);
        check_eq("t1_cmd", cmd, 16'h5030);
        cycle();
        check_eq("t1_done", 16'(cmd_valid), 16'h0);

        // damage then heal with a stalled datapath
        cmd_ready = 0;
        hit(0, 8'h07); cycle();
        hit(1, 8'h00); cycle();
        idle_inputs();
        for (int i = 0; i < 5; i++) begin
            cycle();
            check_eq("t2_stall_cmd", cmd, 16'h2070);
            check_eq("t2_stall_valid", 16'(cmd_valid), 16'h1);
        end
        cmd_ready = 1; cycle();
        cmd_ready = 0; cycle();
        check_eq("t2_heal_cmd", cmd, 16'h10A0);
        cmd_ready = 1; run(2);

        // overfill the FIFO
        cmd_ready = 0;
        for (int i = 0; i < 6; i++) begin
            hit(0, 8'(8'h30 + i)); cycle();
        end
        idle_inputs();
        check_eq("t3_hit_ready", 16'(hit_ready), 16'h0);
        check_eq("t3_drop", 16'(drop_cnt), 16'h1);
        flush = 1; cmd_ready = 1; cycle();
        flush = 0; run(3);

        // starvation guard forces a move after three hits
        xfers.delete();
        cmd_ready = 1;
        hit(0, 8'h01); mv_valid = 1; mv_dir = DIR_UP; cycle();
        mv_valid = 0;
        for (int i = 2; i <= 5; i++) begin
            hit(0, 8'(i)); cycle();
        end
        idle_inputs();
        run(12);
        check_eq("t4_count", 16'(xfers.size()), 16'd6);
        for (int i = 0; i < 6; i++)
            check_eq("t4_order", (i < xfers.size()) ? xfers[i] : 16'hDEAD, exp4[i]);

        // move coalescing while blocked
        xfers.delete();
        cmd_ready = 0;
        hit(0, 8'h09); cycle();
        idle_inputs(); cycle();
        mv_valid = 1; mv_dir = DIR_LEFT; cycle();
        mv_dir = DIR_DOWN; cycle();
        mv_valid = 0; run(2);
        cmd_ready = 1; run(6);
        check_eq("t5_count", 16'(xfers.size()), 16'd2);
        check_eq("t5_first", (xfers.size() > 0) ? xfers[0] : 16'hDEAD, 16'h2090);
        check_eq("t5_move", (xfers.size() > 1) ? xfers[1] : 16'hDEAD, 16'h5020);

        // flush with queued hits and a simultaneous push
        xfers.delete();
        cmd_ready = 0;
        for (int i = 0; i < 4; i++) begin
            hit(0, 8'(8'h11 + i)); cycle();
        end
        hit(0, 8'h22); flush = 1; cycle();
        idle_inputs();
        check_eq("t6_drop", 16'(drop_cnt), 16'h1);
        check_eq("t6_inflight", 16'(cmd_valid), 16'h1);
        cmd_ready = 1; run(6);
        check_eq("t6_count", 16'(xfers.size()), 16'd1);
        check_eq("t6_cmd", (xfers.size() > 0) ? xfers[0] : 16'hDEAD, 16'h2110);
        check_eq("t6_idle", 16'(cmd_valid), 16'h0);
        check_eq("t6_ready", 16'(hit_ready), 16'h1);

        // reset while an instruction is held
        cmd_ready = 0;
        hit(0, 8'h44); cycle();
        idle_inputs(); cycle();
        rst_n = 0;
        #1;
        check_eq("rst_hold_valid", 16'(cmd_valid), 16'h0);
        check_eq("rst_hold_cmd", cmd, 16'h0000);
        check_eq("rst_hold_drop", 16'(drop_cnt), 16'h0);
        model_reset();
        @(posedge clk);
        #2;
        rst_n = 1;
        run(2);

        // drop counter saturation
        cmd_ready = 0;
        hit(0, 8'h05);
        run(300);
        idle_inputs();
        check_eq("sat_drop", 16'(drop_cnt), 16'd255);
        flush = 1; cmd_ready = 1; cycle();
        flush = 0; run(2);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            mv_valid  = ($urandom_range(0, 99) < 20);
            mv_dir    = 2'($urandom_range(0, 3));
            hit_valid = ($urandom_range(0, 99) < 40);
            hit_heal  = ($urandom_range(0, 99) < 30);
            hit_amt   = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            flush     = ($urandom_range(0, 99) < 3);
            cmd_ready = ($urandom_range(0, 99) < 50);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
